// File: rtl/pkt_ingress_pkg.sv
// Shared defaults, FIFO entry layout and framing FSM states for pkt_ingress.
package pkt_ingress_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 16;

   typedef enum logic {ST_IDLE, ST_IN_PKT} state_t;

   // Reference layout at the default width; the top re-declares it at DATA_W.
   typedef struct packed {
      logic                  sop;
      logic                  eop;
      logic [DATA_W_DEF-1:0] data;
   } entry_t;
endpackage

// File: rtl/pkt_ingress_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata shows the head entry, zero when empty.
module pkt_ingress_fifo #(
   parameter int W     = 10,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty,
   output logic [AW:0]  level
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign level   = cnt;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = empty ? '0 : mem[rptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end
endmodule

// File: rtl/pkt_ingress.sv
// Packet ingress: framing check on accepted beats, FWFT buffering toward dut_top.
// Statistics counters are built only when PKT_INGRESS_STATS_EN is defined.
module pkt_ingress
   import pkt_ingress_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_sop,
   input  logic                     in_eop,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_sop,
   output logic                     out_eop,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic [15:0]              pkt_cnt,
   output logic [7:0]               err_cnt
);
   typedef struct packed {
      logic              sop;
      logic              eop;
      logic [DATA_W-1:0] data;
   } beat_t;

   beat_t  wr_ent, rd_ent;
   state_t state;
   logic   rdy_q, full, empty, accept, store, push, pop;

   // rdy_q keeps in_ready low during reset and releases it on the first edge after.
   assign in_ready  = rdy_q && !full;
   assign accept    = in_valid && in_ready;
   assign store     = in_sop || (state == ST_IN_PKT);
   assign push      = accept && store;
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign wr_ent    = '{sop: in_sop, eop: in_eop, data: in_data};
   assign out_sop   = rd_ent.sop;
   assign out_eop   = rd_ent.eop;
   assign out_data  = rd_ent.data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdy_q <= 1'b0;
         state <= ST_IDLE;
      end else begin
         rdy_q <= 1'b1;
         if (push) state <= in_eop ? ST_IDLE : ST_IN_PKT;
      end
   end

   pkt_ingress_fifo #(.W(DATA_W + 2), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (wr_ent),
      .pop   (pop),
      .rdata (rd_ent),
      .full  (full),
      .empty (empty),
      .level (level)
   );

`ifdef PKT_INGRESS_STATS_EN
   logic bad_framing;
   // A missing sop in IDLE or a stray sop inside a packet is a framing error.
   assign bad_framing = accept && ((state == ST_IDLE) ? !in_sop : in_sop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_cnt <= '0;
         err_cnt <= '0;
      end else begin
         if (pop && out_eop && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 1'b1;
         if (bad_framing && err_cnt != 8'hFF)       err_cnt <= err_cnt + 1'b1;
      end
   end
`else
   assign pkt_cnt = '0;
   assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_pkt_ingress.sv
// Scoreboard bench for pkt_ingress: framing model pushes expected beats, monitor pops on output.
module tb_pkt_ingress;
`ifdef PKT_INGRESS_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, out_ready = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_ready, out_valid, out_sop, out_eop;
   logic [7:0] out_data;
   logic [4:0] level;
   logic [15:0] pkt_cnt;
   logic [7:0]  err_cnt;

   int n_chk = 0, n_fail = 0;
   int exp_err = 0, exp_pkt = 0;
   bit m_in_pkt = 1'b0;
   logic [9:0] sb[$];

   always #5 clk = ~clk;

   pkt_ingress dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
      .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
      .out_ready(out_ready), .level(level), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Framing model, applied to each beat the bench sees accepted.
   task automatic model_accept(input logic s, input logic e, input logic [7:0] d);
      if (!m_in_pkt && !s) begin
         exp_err++;
      end else begin
         if (m_in_pkt && s) exp_err++;
         sb.push_back({s, e, d});
         m_in_pkt = !e;
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic s, input logic e, input logic [7:0] d);
      int n = 0;
      in_valid = 1'b1; in_sop = s; in_eop = e; in_data = d;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            model_accept(s, e, d);
            @(posedge clk); #1;
            break;
         end
         if (++n > 300) begin
            chk("send_timeout", 0, 1);
            @(posedge clk); #1;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      while (level != 0 && n < 500) begin
         cyc(1);
         n++;
      end
      chk("drain_done", (level == 0), 1);
   endtask

   task automatic chk_stats(input string tag);
      chk({tag, "_err"}, err_cnt, STATS ? exp_err : 0);
      chk({tag, "_pkt"}, pkt_cnt, STATS ? exp_pkt : 0);
   endtask

   always @(negedge clk) begin
      logic [9:0] e;
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_beat", {out_sop, out_eop, out_data}, 10'h000);
         end else begin
            e = sb.pop_front();
            chk("out_beat", {out_sop, out_eop, out_data}, e);
            if (e[8]) exp_pkt++;
         end
      end
   end

   initial begin
      cyc(2);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_out_data", {out_sop, out_eop, out_data}, 0);
      chk_stats("rst");
      reset = 1'b0;
      chk("in_ready_held", in_ready, 0);
      cyc(1);
      chk("in_ready_rise", in_ready, 1);

      // Single-beat packet, one-cycle FWFT latency.
      out_ready = 1'b1;
      send(1'b1, 1'b1, 8'hA5);
      chk("single_valid", out_valid, 1);
      chk("single_beat", {out_sop, out_eop, out_data}, {2'b11, 8'hA5});
      cyc(1);
      chk_stats("single");

      // Non-sop beat in IDLE is dropped but handshaken.
      send(1'b0, 1'b0, 8'h11);
      chk("drop_level", level, 0);
      chk("drop_valid", out_valid, 0);
      chk_stats("drop");

      // Stray sop inside a packet is stored and counted as an error.
      send(1'b1, 1'b0, 8'h01);
      send(1'b0, 1'b0, 8'h02);
      send(1'b1, 1'b1, 8'h03);
      drain();
      chk_stats("stray_sop");

      // Fill to full, hold the 17th beat, then release out_ready.
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) send(i == 0, i == 15, 8'h20 + 8'(i));
      chk("full_level", level, 16);
      chk("full_in_ready", in_ready, 0);
      fork
         send(1'b1, 1'b1, 8'hEE);
         begin
            cyc(3);
            chk("held_level", level, 16);
            out_ready = 1'b1;
         end
      join
      chk("push_pop_level", level, 15);
      drain();
      chk_stats("full");

      // Random traffic with random backpressure.
      fork
         for (int i = 0; i < 80; i++)
            send($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 8'($urandom));
         repeat (250) begin
            cyc(1);
            out_ready = ($urandom_range(0, 3) != 0);
         end
      join
      drain();
      chk_stats("random");
      chk("random_sb_empty", sb.size(), 0);

      // Reset mid-packet with five stored beats.
      out_ready = 1'b0;
      if (m_in_pkt) send(1'b0, 1'b1, 8'h4F);
      drain();
      out_ready = 1'b0;
      send(1'b1, 1'b0, 8'h50);
      for (int i = 1; i < 5; i++) send(1'b0, 1'b0, 8'h50 + 8'(i));
      chk("pre_rst_level", level, 5);
      reset = 1'b1;
      #1;
      chk("async_level", level, 0);
      chk("async_valid", out_valid, 0);
      chk("async_in_ready", in_ready, 0);
      sb.delete();
      m_in_pkt = 1'b0;
      exp_err = 0;
      exp_pkt = 0;
      cyc(2);
      chk_stats("mid_rst");
      reset = 1'b0;
      cyc(1);
      chk("post_rst_ready", in_ready, 1);
      out_ready = 1'b1;
      send(1'b0, 1'b1, 8'h77);
      cyc(1);
      chk("post_rst_level", level, 0);
      chk("post_rst_valid", out_valid, 0);
      chk_stats("post_rst");
      chk("final_sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
